mont_mul_gen: RTL and testbench
===============================

MONT_MUL_GEN -- requirements
Module: mont_mul_gen

Interface
REQ-001 SHALL have parameter OP_WIDTH, default 256: operand and result width in bits; must be a multiple of WORD_WIDTH and at least 32.
REQ-002 SHALL have parameter WORD_WIDTH, default 32: LSU word width in bits; fixed at 32 in this generation.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have ports start (input, 1) to request an operation and square (input, 1) to select B:=A, both sampled in IDLE.
REQ-006 SHALL have op_address_sel output, 2 bits: operand base select, encoded 0=B, 1=N, 2=A, 3=Result.
REQ-007 SHALL have lsu_ren and lsu_wen outputs, 1 bit each: word read request and word write request.
REQ-008 SHALL have lsu_type output, 2 bits: access size; always 2'b10 (word).
REQ-009 SHALL have lsu_addr_offset output, 32 bits: byte offset from the selected base.
REQ-010 SHALL have lsu_done input, 1 bit: the current LSU access completes in this cycle.
REQ-011 SHALL have lsu_rdata input and lsu_wdata output, 32 bits each: read data and write data.
REQ-012 SHALL have result output, OP_WIDTH bits, registered; and outputs done and busy, 1 bit each.

Function
REQ-013 SHALL compute result = A*B*2^-OP_WIDTH mod N, for N odd and A,B < N; other operands give undefined result but a normal completion.
REQ-014 SHALL sequence the states IDLE -> LOAD_A -> LOAD_B -> LOAD_N -> MUL -> SUB -> WB -> DONE -> IDLE.
REQ-015 SHALL skip LOAD_B when square is 1 at start and copy A into B.
REQ-016 SHALL skip WB when MONT_MUL_WRITEBACK_EN is undefined.
REQ-017 SHALL, in each LOAD state, hold lsu_ren high with offset 4*k for word k = 0..OP_WIDTH/32-1, little-endian word order.
REQ-018 SHALL capture lsu_rdata and advance k on every cycle in which lsu_done is 1.
REQ-019 SHALL keep offset and op_address_sel stable while lsu_done is 0; there is no timeout.
REQ-020 SHALL use radix-2 MUL: OP_WIDTH cycles, each doing T += a_i*B, then T += N if T[0], then T >>= 1, with T OP_WIDTH+2 bits wide and cleared at MUL entry.
REQ-021 SHALL, in SUB (1 cycle), load result with T-N if T >= N, else T[OP_WIDTH-1:0].
REQ-022 SHALL, in WB, drive lsu_wen with op_address_sel=3 and write result words from k=0 upward, advancing on lsu_done.
REQ-023 SHALL, in DONE, hold done=1 until start is seen 0, then go to IDLE; result is held until the next MUL entry.
REQ-024 SHALL drive busy=1 in every state except IDLE and DONE.
REQ-025 SHALL ignore start while busy.
REQ-026 SHALL drive lsu_ren and lsu_wen as mutually exclusive, and never assert either in IDLE, MUL, SUB or DONE.

Reset
REQ-027 SHALL, on rst asserted at any time (including mid-LOAD/MUL/WB), enter IDLE asynchronously.
REQ-028 SHALL reset outputs to: result=0, done=0, busy=0, lsu_ren=0, lsu_wen=0, lsu_addr_offset=0, op_address_sel=0, lsu_wdata=0.
REQ-029 SHALL discard any partially loaded operands on reset; an interrupted write-back leaves memory partially written.

Configuration
REQ-030 SHALL use macro MONT_MUL_WRITEBACK_EN: defined gives the WB state and memory write of the result; undefined removes WB, so lsu_wen is tied 0 and the result is available only on the result port.

Structure
REQ-031 SHALL put the state enum, the op_address_sel encodings (SEL_B, SEL_N, SEL_A, SEL_RES) and LSU_TYPE_WORD in the shared package mont_pkg.
REQ-032 SHALL have one sub-module, mont_step: combinational single radix-2 iteration (T, a_i, B, N -> T_next), parametrised by OP_WIDTH.

Verification
REQ-033 SHALL cover, with OP_WIDTH=32, N=0xFFFFFFFB, A=5, B=0x12345678: result=0x12345678 and done=1.
REQ-034 SHALL cover, with OP_WIDTH=32, N=0xFFFFFFFB, A=5, B=0xFFFFFFFA: result=0xFFFFFFFA, which exercises the final subtraction.
REQ-035 SHALL cover, with OP_WIDTH=32, square=1, A=5: no sel=0 reads occur and result=5.
REQ-036 SHALL cover, with OP_WIDTH=256 and A=0: result=0, with 8 reads each of A, B and N at offsets 0..28; with the macro defined, 8 writes at sel=3.
REQ-037 SHALL cover lsu_done held low for 3 cycles mid-LOAD_N: offset and sel stay frozen, and the result still matches the model.
REQ-038 SHALL cover rst pulsed in MUL cycle 10: outputs go to reset values, a following start gives a correct result, and start toggled while busy is ignored.

Source files
------------

// File: rtl/mont_pkg.sv
// mont_pkg -- shared types and constants for the Montgomery multiplier.
//   state_e        : controller state encoding
//   SEL_*          : op_address_sel encodings (operand base select)
//   LSU_TYPE_WORD  : LSU access size code for a 32-bit word
package mont_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_LOAD_N,
        S_MUL,
        S_SUB,
        S_WB,
        S_DONE
    } state_e;

    localparam logic [1:0] SEL_B   = 2'd0;
    localparam logic [1:0] SEL_N   = 2'd1;
    localparam logic [1:0] SEL_A   = 2'd2;
    localparam logic [1:0] SEL_RES = 2'd3;

    localparam logic [1:0] LSU_TYPE_WORD = 2'b10;

endpackage

// File: rtl/mont_mul_gen_if.sv
// mont_mul_gen_if -- word-wide load/store bus between the multiplier and memory.
//   op_address_sel  : operand base select (B/N/A/Result)
//   lsu_ren/lsu_wen : word read / write request
//   lsu_type        : access size
//   lsu_addr_offset : byte offset from the selected base
//   lsu_done        : current access completes this cycle
//   lsu_rdata       : read data, lsu_wdata : write data
// master = multiplier side, slave = memory side.
interface mont_mul_gen_if;

    logic [1:0]  op_address_sel;
    logic        lsu_ren;
    logic        lsu_wen;
    logic [1:0]  lsu_type;
    logic [31:0] lsu_addr_offset;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic [31:0] lsu_wdata;

    modport master (
        output op_address_sel, lsu_ren, lsu_wen, lsu_type, lsu_addr_offset, lsu_wdata,
        input  lsu_done, lsu_rdata
    );

    modport slave (
        input  op_address_sel, lsu_ren, lsu_wen, lsu_type, lsu_addr_offset, lsu_wdata,
        output lsu_done, lsu_rdata
    );

endinterface

// File: rtl/mont_mul_gen_step.sv
// mont_step -- one combinational radix-2 Montgomery iteration.
//   t      : running accumulator (OP_WIDTH+2 bits)
//   a_i    : current multiplier bit of A
//   b, n   : multiplicand and modulus
//   t_next : (t + a_i*b + q*n) >> 1, q chosen so the sum is even
// With t < 2N and b < N the sum stays below 4N, so two guard bits suffice.
module mont_step #(
    parameter int OP_WIDTH = 256
) (
    input  logic [OP_WIDTH+1:0] t,
    input  logic                a_i,
    input  logic [OP_WIDTH-1:0] b,
    input  logic [OP_WIDTH-1:0] n,
    output logic [OP_WIDTH+1:0] t_next
);

    logic [OP_WIDTH+1:0] s1;
    logic [OP_WIDTH+1:0] s2;

    always_comb begin
        s1     = t + (a_i ? {2'b00, b} : '0);
        s2     = s1 + (s1[0] ? {2'b00, n} : '0);
        t_next = s2 >> 1;
    end

endmodule

// File: rtl/mont_mul_gen.sv
// mont_mul_gen -- radix-2 Montgomery multiplier, result = A*B*2^-OP_WIDTH mod N.
// Operands are fetched word by word (little-endian) over the LSU bus, the
// product is formed in OP_WIDTH single-bit iterations, then one conditional
// subtraction brings it into [0, N).
//   clk, rst     : clock, asynchronous active-high reset
//   start        : request an operation (sampled in IDLE)
//   square       : B := A, skips fetching B (sampled with start)
//   lsu          : load/store bus (master side)
//   result       : registered result, held until the next multiply
//   done, busy   : completion (held until start drops) / operation in flight
// Build option: MONT_MUL_WRITEBACK_EN adds a WB state that stores the result
// to memory (sel=Result); without it lsu_wen is tied low.
module mont_mul_gen
    import mont_pkg::*;
#(
    parameter int OP_WIDTH   = 256,
    parameter int WORD_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                square,
    mont_mul_gen_if.master      lsu,
    output logic [OP_WIDTH-1:0] result,
    output logic                done,
    output logic                busy
);

    localparam int NW = OP_WIDTH / WORD_WIDTH;
    localparam int KW = (NW > 1) ? $clog2(NW) : 1;
    localparam int CW = $clog2(OP_WIDTH);

    state_e              state, nxt;
    logic [KW-1:0]       k;
    logic [CW-1:0]       bit_cnt;
    logic                sq_q;
    logic [OP_WIDTH-1:0] a_q, b_q, n_q;
    logic [OP_WIDTH+1:0] t_q, t_nxt;
    logic [OP_WIDTH-1:0] t_sub, sub_val;
    logic                last_word;
    logic                ren, wen;
    logic [1:0]          sel;

    // Shift a word in at the top; after NW words, word 0 sits at the bottom.
    function automatic logic [OP_WIDTH-1:0] shift_in(input logic [OP_WIDTH-1:0] x,
                                                     input logic [WORD_WIDTH-1:0] w);
        return OP_WIDTH'({w, x} >> WORD_WIDTH);
    endfunction

    mont_step #(.OP_WIDTH(OP_WIDTH)) u_step (
        .t      (t_q),
        .a_i    (a_q[0]),
        .b      (b_q),
        .n      (n_q),
        .t_next (t_nxt)
    );

    assign last_word = (k == KW'(NW - 1));
    // When T >= N the difference is below N, so the low bits are exact.
    assign t_sub     = t_q[OP_WIDTH-1:0] - n_q;
    assign sub_val   = (t_q >= {2'b00, n_q}) ? t_sub : t_q[OP_WIDTH-1:0];

    always_comb begin
        nxt  = state;
        ren  = 1'b0;
        wen  = 1'b0;
        sel  = SEL_B;
        busy = 1'b1;
        done = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) nxt = S_LOAD_A;
            end
            S_LOAD_A: begin
                ren = 1'b1;
                sel = SEL_A;
                if (lsu.lsu_done && last_word) nxt = sq_q ? S_LOAD_N : S_LOAD_B;
            end
            S_LOAD_B: begin
                ren = 1'b1;
                sel = SEL_B;
                if (lsu.lsu_done && last_word) nxt = S_LOAD_N;
            end
            S_LOAD_N: begin
                ren = 1'b1;
                sel = SEL_N;
                if (lsu.lsu_done && last_word) nxt = S_MUL;
            end
            S_MUL: begin
                if (bit_cnt == CW'(OP_WIDTH - 1)) nxt = S_SUB;
            end
            S_SUB: begin
`ifdef MONT_MUL_WRITEBACK_EN
                nxt = S_WB;
`else
                nxt = S_DONE;
`endif
            end
`ifdef MONT_MUL_WRITEBACK_EN
            S_WB: begin
                wen = 1'b1;
                sel = SEL_RES;
                if (lsu.lsu_done && last_word) nxt = S_DONE;
            end
`endif
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (!start) nxt = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            k       <= '0;
            bit_cnt <= '0;
            sq_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            n_q     <= '0;
            t_q     <= '0;
            result  <= '0;
        end else begin
            state <= nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sq_q <= square;
                        k    <= '0;
                    end
                end
                S_LOAD_A: begin
                    if (lsu.lsu_done) begin
                        k   <= last_word ? '0 : k + KW'(1);
                        a_q <= shift_in(a_q, lsu.lsu_rdata);
                        // Squaring: B receives the same word stream as A.
                        if (sq_q) b_q <= shift_in(b_q, lsu.lsu_rdata);
                    end
                end
                S_LOAD_B: begin
                    if (lsu.lsu_done) begin
                        k   <= last_word ? '0 : k + KW'(1);
                        b_q <= shift_in(b_q, lsu.lsu_rdata);
                    end
                end
                S_LOAD_N: begin
                    if (lsu.lsu_done) begin
                        k   <= last_word ? '0 : k + KW'(1);
                        n_q <= shift_in(n_q, lsu.lsu_rdata);
                        if (last_word) begin
                            t_q     <= '0;
                            bit_cnt <= '0;
                        end
                    end
                end
                S_MUL: begin
                    t_q     <= t_nxt;
                    a_q     <= a_q >> 1;  // a_q[0] is always the current bit
                    bit_cnt <= bit_cnt + CW'(1);
                end
                S_SUB: begin
                    result <= sub_val;
                end
                S_WB: begin
                    if (lsu.lsu_done) k <= last_word ? '0 : k + KW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef MONT_MUL_WRITEBACK_EN
    // Separate copy of the result that is shifted down one word per write.
    logic [OP_WIDTH-1:0] wb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                wb_q <= '0;
        else if (state == S_SUB)                wb_q <= sub_val;
        else if (state == S_WB && lsu.lsu_done) wb_q <= shift_in(wb_q, '0);
    end

    assign lsu.lsu_wdata = wb_q[WORD_WIDTH-1:0];
`else
    assign lsu.lsu_wdata = '0;
`endif

    assign lsu.lsu_ren         = ren;
    assign lsu.lsu_wen         = wen;
    assign lsu.op_address_sel  = sel;
    assign lsu.lsu_type        = LSU_TYPE_WORD;
    assign lsu.lsu_addr_offset = 32'({k, 2'b00});

endmodule

// File: tb/tb_mont_mul_gen.sv
// tb_mont_mul_gen -- directed bench for mont_mul_gen.
// Two instances: OP_WIDTH=32 (u_d32) for the hand-computed vectors, stall and
// reset scenarios, and OP_WIDTH=256 (u_d256) for the multi-word fetch.
// Memory is a zero-latency responder; u_d32 can be stalled via stall0.
module tb_mont_mul_gen;
    import mont_pkg::*;

`ifdef MONT_MUL_WRITEBACK_EN
    localparam int EXP_WR1 = 8;
    localparam int EXP_WR0 = 6;
`else
    localparam int EXP_WR1 = 0;
    localparam int EXP_WR0 = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic st0 = 1'b0, sq0 = 1'b0, st1 = 1'b0, sq1 = 1'b0, stall0 = 1'b0;
    logic [31:0]  res0;
    logic [255:0] res1;
    logic done0, busy0, done1, busy1;

    int nchk = 0, nerr = 0;
    int rc0[4], rc1[4];
    int wc0 = 0, wc1 = 0, oerr0 = 0, oerr1 = 0, xerr = 0;
    logic [31:0] m0 [4];
    logic [31:0] m1 [4][8];

    always #5 clk = ~clk;

    mont_mul_gen_if b32 ();
    mont_mul_gen_if b256 ();

    mont_mul_gen #(.OP_WIDTH(32)) u_d32 (
        .clk(clk), .rst(rst), .start(st0), .square(sq0), .lsu(b32),
        .result(res0), .done(done0), .busy(busy0)
    );

    mont_mul_gen #(.OP_WIDTH(256)) u_d256 (
        .clk(clk), .rst(rst), .start(st1), .square(sq1), .lsu(b256),
        .result(res1), .done(done1), .busy(busy1)
    );

    assign b32.lsu_done   = (b32.lsu_ren | b32.lsu_wen) & ~stall0;
    assign b32.lsu_rdata  = m0[b32.op_address_sel];
    assign b256.lsu_done  = b256.lsu_ren | b256.lsu_wen;
    assign b256.lsu_rdata = m1[b256.op_address_sel][b256.lsu_addr_offset[4:2]];

    // Bus monitor: counts accesses per select and flags protocol violations.
    always @(posedge clk) begin
        if ((b32.lsu_ren && b32.lsu_wen) || ((b32.lsu_ren || b32.lsu_wen) && !busy0)) xerr++;
        if ((b256.lsu_ren && b256.lsu_wen) || ((b256.lsu_ren || b256.lsu_wen) && !busy1)) xerr++;
        if (b32.lsu_done) begin
            if (b32.lsu_addr_offset != 32'd0) oerr0++;
            if (b32.lsu_wen) wc0++;
            else             rc0[b32.op_address_sel]++;
        end
        if (b256.lsu_done) begin
            if (b256.lsu_wen) begin
                if (b256.lsu_addr_offset != 32'(4 * (wc1 % 8))) oerr1++;
                wc1++;
            end else begin
                if (b256.lsu_addr_offset != 32'(4 * (rc1[b256.op_address_sel] % 8))) oerr1++;
                rc1[b256.op_address_sel]++;
            end
        end
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait0(input string tag);
        for (int c = 0; c < 500 && done0 !== 1'b1; c++) @(negedge clk);
        chk({tag, "_done"}, done0, 1'b1);
        st0 = 1'b0;
        @(negedge clk);
        chk({tag, "_idle"}, done0, 1'b0);
    endtask

    task automatic run0(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] n, input logic sq, input logic [31:0] exp);
        m0[SEL_A] = a;
        m0[SEL_B] = b;
        m0[SEL_N] = n;
        sq0 = sq;
        st0 = 1'b1;
        @(negedge clk);
        chk({tag, "_busy"}, busy0, 1'b1);
        wait0(tag);
        chk({tag, "_res"}, res0, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog");
        $fatal(1);
    end

    initial begin
        int snap[4];
        logic [31:0] ofs;
        logic [1:0]  sl;

        m0[SEL_RES] = '0;
        for (int i = 0; i < 8; i++) begin
            m1[SEL_A][i]   = 32'd0;
            m1[SEL_B][i]   = 32'(i + 1);
            m1[SEL_N][i]   = 32'hFFFF_FFFF;
            m1[SEL_RES][i] = 32'd0;
        end

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_res",  res0, 32'd0);
        chk("rst_done", done0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_ren",  b32.lsu_ren, 1'b0);
        chk("rst_wen",  b32.lsu_wen, 1'b0);
        chk("rst_ofs",  b32.lsu_addr_offset, 32'd0);
        chk("rst_sel",  b32.op_address_sel, 2'd0);
        chk("rst_wd",   b32.lsu_wdata, 32'd0);
        chk("lsu_type", b32.lsu_type, 2'b10);
        rst = 1'b0;
        @(negedge clk);

        // A = R mod N, so result = B
        snap = rc0;
        run0("v1", 32'd5, 32'h1234_5678, 32'hFFFF_FFFB, 1'b0, 32'h1234_5678);
        chk("v1_rdb", rc0[SEL_B] - snap[SEL_B], 1);
        // B = N-1: final subtraction path
        run0("v2", 32'd5, 32'hFFFF_FFFA, 32'hFFFF_FFFB, 1'b0, 32'hFFFF_FFFA);
        // square: B memory deliberately different, must not be read
        snap = rc0;
        run0("sq", 32'd5, 32'hDEAD_BEEF, 32'hFFFF_FFFB, 1'b1, 32'd5);
        chk("sq_nob", rc0[SEL_B] - snap[SEL_B], 0);
        chk("sq_rda", rc0[SEL_A] - snap[SEL_A], 1);
        // 2*2*R^-1 mod N: 5*0x33333333 = N+4
        run0("v3", 32'd2, 32'd2, 32'hFFFF_FFFB, 1'b0, 32'h3333_3333);

        // 256-bit, A = 0
        snap = rc1;
        sq1 = 1'b0;
        st1 = 1'b1;
        @(negedge clk);
        chk("w_busy", busy1, 1'b1);
        for (int c = 0; c < 2000 && done1 !== 1'b1; c++) @(negedge clk);
        chk("w_done", done1, 1'b1);
        st1 = 1'b0;
        @(negedge clk);
        chk("w_res", res1, 256'd0);
        chk("w_rda", rc1[SEL_A] - snap[SEL_A], 8);
        chk("w_rdb", rc1[SEL_B] - snap[SEL_B], 8);
        chk("w_rdn", rc1[SEL_N] - snap[SEL_N], 8);
        chk("w_wr",  wc1, EXP_WR1);
        chk("w_ofs", oerr1, 0);

        // lsu_done low for 3 cycles during LOAD_N
        m0[SEL_A] = 32'd5;
        m0[SEL_B] = 32'h0BAD_F00D;
        m0[SEL_N] = 32'hFFFF_FFFB;
        sq0 = 1'b0;
        st0 = 1'b1;
        for (int c = 0; c < 50 && !(b32.lsu_ren && b32.op_address_sel == SEL_N); c++)
            @(negedge clk);
        chk("st_seen", b32.op_address_sel, SEL_N);
        stall0 = 1'b1;
        ofs = b32.lsu_addr_offset;
        sl  = b32.op_address_sel;
        repeat (3) begin
            @(negedge clk);
            chk("st_ofs", b32.lsu_addr_offset, ofs);
            chk("st_sel", b32.op_address_sel, sl);
            chk("st_ren", b32.lsu_ren, 1'b1);
        end
        stall0 = 1'b0;
        wait0("st");
        chk("st_res", res0, 32'h0BAD_F00D);

        // reset in MUL cycle 10
        m0[SEL_A] = 32'd2;
        m0[SEL_B] = 32'd2;
        snap = rc0;
        st0 = 1'b1;
        for (int c = 0; c < 50 && rc0[SEL_N] == snap[SEL_N]; c++) @(negedge clk);
        chk("rm_ldn", rc0[SEL_N] - snap[SEL_N], 1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        st0 = 1'b0;
        #1;
        chk("rm_res",  res0, 32'd0);
        chk("rm_busy", busy0, 1'b0);
        chk("rm_done", done0, 1'b0);
        chk("rm_ren",  b32.lsu_ren, 1'b0);
        chk("rm_wen",  b32.lsu_wen, 1'b0);
        chk("rm_ofs",  b32.lsu_addr_offset, 32'd0);
        chk("rm_sel",  b32.op_address_sel, 2'd0);
        chk("rm_wd",   b32.lsu_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // restart after reset, start toggled while busy
        m0[SEL_A] = 32'd5;
        m0[SEL_B] = 32'h1234_5678;
        snap = rc0;
        st0 = 1'b1;
        @(negedge clk);
        chk("tg_busy", busy0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            st0 = ~st0;
            @(negedge clk);
        end
        wait0("tg");
        chk("tg_res", res0, 32'h1234_5678);
        chk("tg_rda", rc0[SEL_A] - snap[SEL_A], 1);

        chk("bus_excl", xerr, 0);
        chk("ofs0",     oerr0, 0);
        chk("wr0",      wc0, EXP_WR0);

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
